// File: rtl/osc_sched_pkg.sv
// osc_scheduler shared definitions
// FSM state codes and width defaults
package osc_sched_pkg;

  localparam int N_OSC_DEF      = 2;
  localparam int DT_WIDTH_DEF   = 32;
  localparam int TIME_WIDTH_DEF = 48;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_MIN   = 2'd2;
  localparam logic [1:0] S_APPLY = 2'd3;

endpackage

// File: rtl/osc_sched_chan.sv
// osc_scheduler per-channel oscillator
// remaining-time counter, toggle and reload
module osc_sched_chan
  import osc_sched_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load,
  input  logic                apply,
  input  logic [DT_WIDTH-1:0] dt_q,
  input  logic [DT_WIDTH-1:0] t_lo,
  input  logic [DT_WIDTH-1:0] t_hi,
  output logic [DT_WIDTH-1:0] rem,
  output logic                osc
);

  logic [DT_WIDTH-1:0] lo_c;
  logic [DT_WIDTH-1:0] hi_c;

  // zero half-periods clamp to 1 so time always advances
  always_comb begin
    lo_c = t_lo;
    hi_c = t_hi;
    if (t_lo == '0) lo_c = DT_WIDTH'(1);
    if (t_hi == '0) hi_c = DT_WIDTH'(1);
  end

  // load, count down, or toggle and reload on edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem <= '0;
      osc <= 1'b0;
    end else if (load) begin
      rem <= lo_c;
      osc <= 1'b0;
    end else if (apply) begin
      if (rem == dt_q) begin
        osc <= ~osc;
        rem <= osc ? lo_c : hi_c;
      end else begin
        rem <= rem - dt_q;
      end
    end
  end

endmodule

// File: rtl/osc_scheduler.sv
// osc_scheduler top: FSM, min reduction
// and emulation-time accumulator
module osc_scheduler
  import osc_sched_pkg::*;
#(
  parameter int N_OSC      = N_OSC_DEF,
  parameter int DT_WIDTH   = DT_WIDTH_DEF,
  parameter int TIME_WIDTH = TIME_WIDTH_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           en_i,
  input  logic [N_OSC-1:0][DT_WIDTH-1:0] t_lo_i,
  input  logic [N_OSC-1:0][DT_WIDTH-1:0] t_hi_i,
  output logic [N_OSC-1:0]               osc_o,
  output logic [TIME_WIDTH-1:0]          emu_time_o,
  output logic [DT_WIDTH-1:0]            dt_o,
  output logic                           step_o,
  output logic                           ovf_o
);

  localparam int SW =
    (TIME_WIDTH > DT_WIDTH ? TIME_WIDTH : DT_WIDTH) + 1;

  logic [1:0]          state;
  logic                loaded;
  logic [DT_WIDTH-1:0] dt_q;
  logic [DT_WIDTH-1:0] dt_min;
  logic [DT_WIDTH-1:0] rem [N_OSC];
  logic [SW-1:0]       sum;
  logic                load_c;
  logic                apply_c;

  assign load_c  = (state == S_LOAD);
  assign apply_c = (state == S_APPLY);

  for (genvar g = 0; g < N_OSC; g++) begin : g_chan
    osc_sched_chan #(
      .DT_WIDTH(DT_WIDTH)
    ) u_chan (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .load  (load_c),
      .apply (apply_c),
      .dt_q  (dt_q),
      .t_lo  (t_lo_i[g]),
      .t_hi  (t_hi_i[g]),
      .rem   (rem[g]),
      .osc   (osc_o[g])
    );
  end

  // smallest remaining time-to-edge across channels
  always_comb begin
    dt_min = rem[0];
    for (int i = 1; i < N_OSC; i++) begin
      if (rem[i] < dt_min) dt_min = rem[i];
    end
  end

  // widened add exposes the wrap as upper bits
  always_comb begin
    sum = SW'(emu_time_o) + SW'(dt_q);
  end

  // sequencing, step strobe and time accumulation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      loaded     <= 1'b0;
      dt_q       <= '0;
      emu_time_o <= '0;
      dt_o       <= '0;
      step_o     <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      step_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (en_i) state <= loaded ? S_MIN : S_LOAD;
        end
        S_LOAD: begin
          loaded <= 1'b1;
          state  <= S_MIN;
        end
        S_MIN: begin
          dt_q  <= dt_min;
          state <= en_i ? S_APPLY : S_IDLE;
        end
        S_APPLY: begin
          emu_time_o <= sum[TIME_WIDTH-1:0];
          if (|sum[SW-1:TIME_WIDTH]) ovf_o <= 1'b1;
          dt_o   <= dt_q;
          step_o <= 1'b1;
          state  <= S_MIN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_scheduler.sv
// osc_scheduler bench: directed scenarios
// plus random half-periods vs edge-time model
module tb_osc_scheduler;

  localparam int NO = 2;
  localparam int DW = 16;
  localparam int TW = 8;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     en = 1'b0;
  logic [NO-1:0][DW-1:0]    t_lo = '0;
  logic [NO-1:0][DW-1:0]    t_hi = '0;
  logic [NO-1:0]            osc;
  logic [TW-1:0]            emu_time;
  logic [DW-1:0]            dt;
  logic                     step;
  logic                     ovf;

  int passed = 0;
  int total  = 0;

  longint m_now;
  longint m_edge [NO];
  logic   m_lvl  [NO];
  logic   m_ovf;
  longint m_dt;

  always #5 clk = ~clk;

  osc_scheduler #(
    .N_OSC     (NO),
    .DT_WIDTH  (DW),
    .TIME_WIDTH(TW)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .en_i      (en),
    .t_lo_i    (t_lo),
    .t_hi_i    (t_hi),
    .osc_o     (osc),
    .emu_time_o(emu_time),
    .dt_o      (dt),
    .step_o    (step),
    .ovf_o     (ovf)
  );

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  function automatic longint hp(logic [DW-1:0] v);
    return (v == 0) ? 64'd1 : longint'(v);
  endfunction

  // edge times held as absolute emulation time
  task automatic m_reset();
    m_now = 0;
    m_ovf = 1'b0;
    for (int i = 0; i < NO; i++) begin
      m_edge[i] = 0;
      m_lvl[i]  = 1'b0;
    end
  endtask

  task automatic m_load();
    for (int i = 0; i < NO; i++) begin
      m_lvl[i]  = 1'b0;
      m_edge[i] = m_now + hp(t_lo[i]);
    end
  endtask

  task automatic m_step();
    longint nxt;
    nxt = m_edge[0];
    for (int i = 1; i < NO; i++)
      if (m_edge[i] < nxt) nxt = m_edge[i];
    m_dt  = nxt - m_now;
    m_now = nxt;
    if (m_now >= 256) m_ovf = 1'b1;
    for (int i = 0; i < NO; i++) begin
      if (m_edge[i] == m_now) begin
        m_lvl[i] = ~m_lvl[i];
        m_edge[i] += hp(m_lvl[i] ? t_hi[i] : t_lo[i]);
      end
    end
  endtask

  function automatic logic [NO-1:0] m_osc();
    logic [NO-1:0] v;
    for (int i = 0; i < NO; i++) v[i] = m_lvl[i];
    return v;
  endfunction

  task automatic wait_step(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!step && cyc < 60);
    if (!step) chk("step_timeout", 64'(step), 64'd1);
  endtask

  task automatic do_step(string tag);
    int c;
    wait_step(c);
    m_step();
    chk({tag, "_time"}, 64'(emu_time), 64'(m_now % 256));
    chk({tag, "_dt"},   64'(dt),       64'(m_dt));
    chk({tag, "_osc"},  64'(osc),      64'(m_osc()));
    chk({tag, "_ovf"},  64'(ovf),      64'(m_ovf));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_osc"},  64'(osc),      64'd0);
    chk({tag, "_time"}, 64'(emu_time), 64'd0);
    chk({tag, "_dt"},   64'(dt),       64'd0);
    chk({tag, "_step"}, 64'(step),     64'd0);
    chk({tag, "_ovf"},  64'(ovf),      64'd0);
  endtask

  task automatic restart(logic [DW-1:0] lo0, logic [DW-1:0] hi0,
                         logic [DW-1:0] lo1, logic [DW-1:0] hi1);
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    t_lo[0] = lo0; t_hi[0] = hi0;
    t_lo[1] = lo1; t_hi[1] = hi1;
    m_reset();
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    m_load();
  endtask

  initial begin
    int c;
    int seen;
    logic [TW-1:0] held_t;
    logic [NO-1:0] held_o;

    // reset state
    repeat (2) @(negedge clk);
    chk_zero("reset");

    // two channels, overlapping edges, first-step latency
    t_lo[0] = 3; t_hi[0] = 5;
    t_lo[1] = 4; t_hi[1] = 4;
    m_reset();
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    m_load();
    wait_step(c);
    chk("first_latency", 64'(c), 64'd4);
    m_step();
    chk("s1_time", 64'(emu_time), 64'd3);
    chk("s1_dt",   64'(dt),       64'd3);
    chk("s1_osc",  64'(osc),      64'b01);
    chk("s1_mtime", 64'(emu_time), 64'(m_now));

    // pause: no steps, outputs held
    en = 1'b0;
    held_t = emu_time;
    held_o = osc;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (step) seen++;
    end
    chk("pause_steps", 64'(seen), 64'd0);
    chk("pause_time",  64'(emu_time), 64'(held_t));
    chk("pause_osc",   64'(osc), 64'(held_o));
    en = 1'b1;
    do_step("s2");
    chk("s2_osc_lit", 64'(osc), 64'b11);
    do_step("s3");
    chk("s3_time_lit", 64'(emu_time), 64'd8);
    chk("s3_osc_lit",  64'(osc), 64'b00);

    // live change of ch1 high half-period while ch1 is low
    while (m_lvl[1] != 1'b0) do_step("lv_pre");
    t_hi[1] = 9;
    for (int k = 0; k < 6; k++) do_step("live");

    // random half-periods, changed on the fly
    restart(16'(1 + $urandom_range(0, 6)),
            16'(1 + $urandom_range(0, 6)),
            16'(1 + $urandom_range(0, 6)),
            16'(1 + $urandom_range(0, 6)));
    for (int k = 0; k < 40; k++) begin
      do_step("rnd");
      if ($urandom_range(0, 1) == 1) begin
        int ch;
        ch = $urandom_range(0, NO - 1);
        if ($urandom_range(0, 1) == 1)
          t_lo[ch] = 16'($urandom_range(0, 9));
        else
          t_hi[ch] = 16'($urandom_range(0, 9));
      end
    end

    // zero half-period clamp
    restart(0, 0, 5, 5);
    for (int k = 0; k < 6; k++) begin
      do_step("zero");
      chk("zero_dt_lit", 64'(dt), 64'd1);
    end

    // emulation-time wrap and sticky overflow
    restart(100, 100, 100, 100);
    do_step("wrap1");
    do_step("wrap2");
    chk("wrap2_ovf_lit", 64'(ovf), 64'd0);
    do_step("wrap3");
    chk("wrap3_time_lit", 64'(emu_time), 64'd44);
    chk("wrap3_ovf_lit",  64'(ovf), 64'd1);
    do_step("wrap4");
    chk("wrap4_ovf_lit",  64'(ovf), 64'd1);

    // reset in the middle of an APPLY cycle
    restart(3, 5, 4, 4);
    do_step("pre_rst");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    m_reset();
    rst_n = 1'b1;
    m_load();
    wait_step(c);
    chk("rst_latency", 64'(c), 64'd4);
    m_step();
    chk("post_rst_time", 64'(emu_time), 64'(m_now));
    chk("post_rst_osc",  64'(osc), 64'(m_osc()));
    do_step("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/osc_scheduler.md
# osc_scheduler

Synthesizable emulation-time scheduler for the multi-clock unittest. It owns N oscillators, each with a programmable low and high half-period, and repeatedly advances emulation time by the smallest remaining time-to-edge across all channels. It toggles every oscillator whose edge falls on that step. It feeds `osc_o[i]` to the per-oscillator checkers and publishes `emu_time_o`, `dt_o` and `step_o` to the time-manager/debug path.

## Interface
Parameters:
- `N_OSC`, default 2: number of oscillator channels (1..16).
- `DT_WIDTH`, default 32: width of half-period and remaining-time values, in emulation-time LSBs.
- `TIME_WIDTH`, default 48: width of the emulation-time accumulator.

Ports:
- `clk_i`  in  1: sole clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `en_i`  in  1: run enable; low pauses stepping.
- `t_lo_i`  in  N_OSC x DT_WIDTH: low half-period per channel.
- `t_hi_i`  in  N_OSC x DT_WIDTH: high half-period per channel.
- `osc_o`  out  N_OSC: oscillator outputs.
- `emu_time_o`  out  TIME_WIDTH: accumulated emulation time.
- `dt_o`  out  DT_WIDTH: size of the most recent step.
- `step_o`  out  1: one-cycle strobe, asserted in the cycle `emu_time_o` updates.
- `ovf_o`  out  1: sticky flag, set when `emu_time_o` wraps.

## Operation
- **States:** IDLE, LOAD, MIN, APPLY.
- **Reset values:** state=IDLE, `loaded`=0, all `rem[i]`=0, `osc_o`=0, `emu_time_o`=0, `dt_o`=0, `step_o`=0, `ovf_o`=0.
- **IDLE:**
  - If `en_i`=1 and `loaded`=0, go to LOAD.
  - If `en_i`=1 and `loaded`=1, go to MIN.
  - Otherwise stay in IDLE; all state is held.
- **LOAD:** `rem[i]` = `t_lo_i[i]`; `osc_o`=0; `loaded`=1; go to MIN.
- **MIN:**
  - Register `dt_q` = min over i of `rem[i]`.
  - Go to APPLY if `en_i`=1, else go to IDLE.
- **APPLY:**
  - `emu_time_o` += `dt_q`, modulo 2^TIME_WIDTH. On carry-out, set `ovf_o`=1 (sticky).
  - `dt_o` = `dt_q`; `step_o`=1 for this cycle only.
  - Per channel, if `rem[i]` == `dt_q`:
    - toggle `osc_o[i]`;
    - reload `rem[i]` with `t_hi_i[i]` if the old `osc_o[i]` was 0, else `t_lo_i[i]`.
  - Per channel, otherwise: `rem[i]` -= `dt_q`.
  - Go to MIN.
- **Half-period sampling:** `t_lo_i` and `t_hi_i` are sampled only at LOAD or at reload, so a change takes effect at that channel's next edge.
- **Zero half-period:** a value of 0 is treated as 1 at load/reload, which guarantees forward progress.
- **Simultaneous edges:** every channel that ties for the minimum toggles in the same APPLY cycle.
- **Pause:** `en_i` falling takes effect at the next MIN. An in-flight APPLY always completes. Resume continues from the held `rem`, `osc_o` and time; there is no reload.
- **Reset mid-operation:** asynchronous; all outputs return to their reset values immediately.

## Timing
- **First step:** with `en_i` high at IDLE in cycle 0, LOAD runs in cycle 1 and MIN in cycle 2. `step_o` and the first `osc_o` toggle appear in the cycle-3 register update, visible at cycle 4.
- **Steady-state throughput:** one step every 2 cycles (MIN, APPLY).
- **Update alignment:** `osc_o`, `emu_time_o` and `dt_o` all update on the same edge that raises `step_o`.
- **Registered outputs:** all outputs are registered; there are no combinational paths from input to output.

## Structure
- **Package `osc_sched_pkg`:** state enum (IDLE, LOAD, MIN, APPLY) and the width defaults.
- **Sub-module `osc_sched_chan`:** one per channel, instantiated via a generate loop. It holds `rem` and `osc`, and implements load, subtract, reload/toggle and the zero-clamp. Inputs: `load`, `apply`, `dt_q`, `t_lo`, `t_hi`. Outputs: `rem`, `osc`.
- **Top level:** contains the FSM, the combinational min reduction over the `rem` values, and the time accumulator.

## Test plan
- **Two channels, overlapping edges.** N_OSC=2; ch0 lo/hi = 3/5; ch1 lo/hi = 4/4. Required steps:
  - dt=3 at time 3, `osc_o`=01;
  - dt=1 at time 4, `osc_o`=11;
  - dt=4 at time 8, `osc_o`=00 (simultaneous toggle).
- **Pause and resume.** Drop `en_i` after the first `step_o`, hold it low 10 cycles, then raise it.
  - While low: no `step_o`, outputs held.
  - After resume: the sequence continues at time 4, identical to the first scenario.
- **Zero half-period clamp.** ch0 lo/hi = 0/0. Required: ch0 toggles on every step with dt=1.
- **Time wrap.** TIME_WIDTH=8; ch0 lo/hi = 100/100. Required: after the third step, `emu_time_o`=44 and `ovf_o`=1, and `ovf_o` stays 1.
- **Reset mid-run.** Assert `rst_ni`=0 in the middle of an APPLY cycle. Required: outputs are 0 immediately. After release with `en_i`=1, LOAD is re-entered and the first `step_o` comes 3 cycles later.
- **Live half-period change.** Change ch1 `t_hi_i` while ch1 is low. Required: the new value is used at the next rising edge only.
